bcd_time_counter: RTL and testbench

Free-running hh:mm:ss time-of-day counter in packed BCD. Its six 4-bit digit outputs feed the six-channel digit selector directly, ahead of the seven-segment decoder and scan logic on the Basys2 display path. A clock prescaler generates a once-per-second advance, and two single-cycle adjust strobes allow setting minutes and hours.

---
 rtl/bcd_time_counter_if.sv | 24 ++
 rtl/bcd_time_counter.sv | 101 ++++++++++
 tb/tb_bcd_time_counter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bcd_time_counter_if.sv
// Control strobes and BCD digit outputs of the hh:mm:ss time counter.
// The master drives run/adjust inputs and reads the six digit channels plus the tick.
interface bcd_time_counter_if;
    logic       en;
    logic       adj_min;
    logic       adj_hour;
    logic [3:0] ch0;
    logic [3:0] ch1;
    logic [3:0] ch2;
    logic [3:0] ch3;
    logic [3:0] ch4;
    logic [3:0] ch5;
    logic       sec_tick;

    modport master (
        output en, adj_min, adj_hour,
        input  ch0, ch1, ch2, ch3, ch4, ch5, sec_tick
    );

    modport slave (
        input  en, adj_min, adj_hour,
        output ch0, ch1, ch2, ch3, ch4, ch5, sec_tick
    );
endinterface

// File: rtl/bcd_time_counter.sv
// Free-running hh:mm:ss counter in packed BCD with a one-second prescaler.
// Each digit is its own counter; carries are explicit enables, adjust strobes OR into them.
module bcd_time_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic               clk,
    input  logic               rst,
    bcd_time_counter_if.slave  bus
);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [3:0] s0_q, s0_d, s1_q, s1_d;
    logic [3:0] m0_q, m0_d, m1_q, m1_d;
    logic [3:0] h0_q, h0_d, h1_q, h1_d;
    logic       sec_tick_q;

    logic tick_w, sec_carry_w, min_adv_w, min_carry_w, hour_adv_w;

    assign tick_w      = bus.en && (presc_q == PRESC_LAST);
    assign sec_carry_w = tick_w && (s0_q == 4'd9) && (s1_q == 4'd5);
    assign min_adv_w   = sec_carry_w || bus.adj_min;
    // An adjust-driven minute wrap must not roll the hours.
    assign min_carry_w = sec_carry_w && (m0_q == 4'd9) && (m1_q == 4'd5);
    assign hour_adv_w  = min_carry_w || bus.adj_hour;

    always_comb begin
        presc_d = presc_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        m0_d    = m0_q;
        m1_d    = m1_q;
        h0_d    = h0_q;
        h1_d    = h1_q;

        if (bus.en) begin
            presc_d = tick_w ? '0 : presc_q + 1'b1;
        end

        if (tick_w) begin
            if (s0_q == 4'd9) begin
                s0_d = 4'd0;
                s1_d = (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
            end else begin
                s0_d = s0_q + 4'd1;
            end
        end

        if (min_adv_w) begin
            if (m0_q == 4'd9) begin
                m0_d = 4'd0;
                m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
            end else begin
                m0_d = m0_q + 4'd1;
            end
        end

        if (hour_adv_w) begin
            if ((h1_q == 4'd2) && (h0_q == 4'd3)) begin
                h0_d = 4'd0;
                h1_d = 4'd0;
            end else if (h0_q == 4'd9) begin
                h0_d = 4'd0;
                h1_d = h1_q + 4'd1;
            end else begin
                h0_d = h0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            s0_q       <= 4'd0;
            s1_q       <= 4'd0;
            m0_q       <= 4'd0;
            m1_q       <= 4'd0;
            h0_q       <= 4'd0;
            h1_q       <= 4'd0;
            sec_tick_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            m0_q       <= m0_d;
            m1_q       <= m1_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            sec_tick_q <= tick_w;
        end
    end

    assign bus.ch0      = s0_q;
    assign bus.ch1      = s1_q;
    assign bus.ch2      = m0_q;
    assign bus.ch3      = m1_q;
    assign bus.ch4      = h0_q;
    assign bus.ch5      = h1_q;
    assign bus.sec_tick = sec_tick_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Checks the BCD time counter against an hours/minutes/seconds integer model,
// with directed corner cases followed by a randomized run.
module tb_bcd_time_counter;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_time_counter_if bus ();

    bcd_time_counter #(.TICK_DIV(DIV), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int mh, mm, ms, en_cnt;
    bit mtick;

    logic [23:0] dut_t;
    assign dut_t = {bus.ch5, bus.ch4, bus.ch3, bus.ch2, bus.ch1, bus.ch0};

    function automatic logic [23:0] pack(int h, int m, int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(string tag, logic [23:0] got, logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(bit e, bit am, bit ah);
        bit tk, sc, mc;
        tk = 0; sc = 0; mc = 0;
        if (e) begin
            en_cnt++;
            tk = (en_cnt % DIV == 0);
        end
        if (tk) begin
            ms++;
            if (ms == 60) begin ms = 0; sc = 1; end
        end
        if (sc || am) begin
            mm++;
            if (mm == 60) begin mm = 0; mc = sc; end
        end
        if (mc || ah) mh = (mh + 1) % 24;
        mtick = tk;
    endtask

    task automatic step(bit e, bit am, bit ah);
        @(negedge clk);
        bus.en = e; bus.adj_min = am; bus.adj_hour = ah;
        @(posedge clk);
        model_edge(e, am, ah);
        #1;
        chk("time", dut_t, pack(mh, mm, ms));
        chk("tick", 24'(bus.sec_tick), 24'(mtick));
    endtask

    // Asserts reset between clock edges, checks the immediate clear, releases on a falling edge.
    task automatic do_reset();
        #3;
        bus.en = 0; bus.adj_min = 0; bus.adj_hour = 0;
        rst = 1'b1;
        #1;
        mh = 0; mm = 0; ms = 0; en_cnt = 0; mtick = 0;
        chk("rst_time", dut_t, 24'h0);
        chk("rst_tick", 24'(bus.sec_tick), 24'h0);
        @(posedge clk);
        #1;
        chk("rst_hold", dut_t, 24'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic goto_time(int h, int m, int s);
        do_reset();
        for (int i = 0; i < h; i++) step(0, 0, 1);
        for (int i = 0; i < m; i++) step(0, 1, 0);
        for (int i = 0; i < s * DIV; i++) step(1, 0, 0);
        chk("goto", dut_t, pack(h, m, s));
    endtask

    initial begin
        int first_tick;
        bit seen;
        bus.en = 0; bus.adj_min = 0; bus.adj_hour = 0;
        mh = 0; mm = 0; ms = 0; en_cnt = 0; mtick = 0;
        #12;
        do_reset();

        // 40 enabled cycles: ticks on every 4th, ten seconds total.
        first_tick = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1, 0, 0);
            if (bus.sec_tick && first_tick < 0) first_tick = i;
        end
        chk("first_tick", 24'(first_tick), 24'(DIV));
        chk("ten_sec", dut_t, pack(0, 0, 10));

        // Pause holds the prescaler at its last value.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            if (bus.sec_tick) seen = 1;
        end
        chk("paused_tick", 24'(seen), 24'h0);
        step(1, 0, 0);
        chk("resume_tick", 24'(bus.sec_tick), 24'h1);
        chk("resume_time", dut_t, pack(0, 0, 1));

        goto_time(0, 59, 59);
        for (int i = 0; i < DIV; i++) step(1, 0, 0);
        chk("hour_roll", dut_t, pack(1, 0, 0));

        goto_time(23, 59, 59);
        for (int i = 0; i < DIV; i++) step(1, 0, 0);
        chk("day_wrap", dut_t, 24'h0);

        goto_time(9, 0, 0);
        step(0, 0, 1);
        chk("adj_h09", dut_t, pack(10, 0, 0));

        goto_time(23, 0, 0);
        step(0, 0, 1);
        chk("adj_h23", dut_t, pack(0, 0, 0));

        goto_time(3, 59, 7);
        step(0, 1, 0);
        chk("adj_m59", dut_t, pack(3, 0, 7));

        goto_time(4, 5, 59);
        for (int i = 0; i < DIV - 1; i++) step(1, 0, 0);
        step(1, 1, 0);
        chk("adj_on_carry", dut_t, pack(4, 6, 0));

        goto_time(12, 34, 56);
        step(1, 0, 0);
        step(1, 0, 0);
        do_reset();
        seen = 0;
        for (int i = 0; i < DIV - 1; i++) begin
            step(1, 0, 0);
            if (bus.sec_tick) seen = 1;
        end
        chk("post_rst_early", 24'(seen), 24'h0);
        step(1, 0, 0);
        chk("post_rst_tick", 24'(bus.sec_tick), 24'h1);

        // Randomized run, started near the day boundary to exercise wraps.
        goto_time(23, 58, 30);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 7) != 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 19) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
